// File: rtl/cute_pkg.sv
// Shared types and constants for the cute instruction feeder: FSM states,
// opcode field position and the opcodes that carry a second word.
package cute_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_OPERAND,
    S_WAIT,
    S_HALT,
    S_ERR
  } state_e;

  localparam int OP_HI = 8;
  localparam int OP_LO = 6;
  localparam int OPW   = OP_HI - OP_LO + 1;

  localparam logic [OPW-1:0] IMM_OP_C    = 3'b001;
  localparam logic [OPW-1:0] BR_OP_C     = 3'b111;
  localparam logic [8:0]     HALT_WORD_C = 9'h000;

endpackage

// File: rtl/cute_program_feeder_if.sv
// Instruction/completion handshake between the feeder (master) and the
// cute processor (slave).
interface cute_program_feeder_if #(
  parameter int DW = 9
);
  logic [DW-1:0] DIN;
  logic          Run;
  logic          done;
  logic          jmp;

  modport master (output DIN, Run, input done, jmp);
  modport slave  (input DIN, Run, output done, jmp);
endinterface

// File: rtl/cute_prog_mem.sv
// Program store: synchronous write, two combinational read ports, no reset.
module cute_prog_mem #(
  parameter int DW = 9,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1
);
  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];
endmodule

// File: rtl/cute_program_feeder.sv
// Sequencer feeding the cute processor: issues program words one at a time,
// follows branches, stops on the halt word or a watchdog timeout.
module cute_program_feeder
  import cute_pkg::*;
#(
  parameter int             DW        = 9,
  parameter int             AW        = 5,
  parameter logic [OPW-1:0] IMM_OP    = IMM_OP_C,
  parameter logic [OPW-1:0] BR_OP     = BR_OP_C,
  parameter logic [DW-1:0]  HALT_WORD = DW'(HALT_WORD_C),
  parameter int             TIMEOUT   = 15
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic                  load_en,
  input  logic [AW-1:0]         load_addr,
  input  logic [DW-1:0]         load_data,
  cute_program_feeder_if.master cpu,
  output logic [AW-1:0]         pc,
  output logic                  busy,
  output logic                  halted,
  output logic                  timeout_err
);
  localparam int             WDW     = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d, pc_nx1;
  logic [DW-1:0]  din_q, din_d, din_hold;
  logic           run_q, run_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           two_q, two_d, br_q, br_d;
  logic [DW-1:0]  word_nx, word_op;
  logic [OPW-1:0] opc;
  logic           mem_we;

  assign pc_nx1 = pc_q + AW'(1);
  assign mem_we = (state_q == S_IDLE) && load_en;
  assign opc    = din_q[OP_HI:OP_LO];

  // Port 0 looks ahead at the word the next ISSUE cycle will drive, so Run/DIN
  // can be registered; port 1 supplies the operand / branch target.
  cute_prog_mem #(.DW(DW), .AW(AW)) u_mem (
    .clk    (clk),
    .we     (mem_we),
    .waddr  (load_addr),
    .wdata  (load_data),
    .raddr0 (pc_d),
    .raddr1 (pc_nx1),
    .rdata0 (word_nx),
    .rdata1 (word_op)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wd_d     = wd_q;
    two_d    = two_q;
    br_d     = br_q;
    din_hold = din_q;
    case (state_q)
      S_IDLE:
        if (start && !load_en) begin
          pc_d    = '0;
          state_d = S_ISSUE;
        end
      S_ISSUE: begin
        two_d = (opc == IMM_OP) || (opc == BR_OP);
        br_d  = (opc == BR_OP);
        wd_d  = '0;
        // run_q low in ISSUE means the fetched word was the halt sentinel
        if (!run_q) begin
          state_d  = S_HALT;
          din_hold = '0;
        end else if (two_d) begin
          state_d  = S_OPERAND;
          din_hold = word_op;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_OPERAND: state_d = S_WAIT;
      S_WAIT:
        if (cpu.done) begin
          wd_d    = '0;
          state_d = S_ISSUE;
          if (br_q && cpu.jmp) pc_d = word_op[AW-1:0];
          else if (two_q)      pc_d = pc_q + AW'(2);
          else                 pc_d = pc_nx1;
        end else if (wd_q == WD_LAST) begin
          state_d  = S_ERR;
          din_hold = '0;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      S_HALT, S_ERR:
        if (start) begin
          pc_d    = '0;
          state_d = S_ISSUE;
        end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    run_d = 1'b0;
    din_d = din_hold;
    if (state_d == S_ISSUE) begin
      run_d = (word_nx != HALT_WORD);
      din_d = run_d ? word_nx : '0;
    end
  end

  always_ff @(posedge clk or posedge Reset)
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      din_q   <= '0;
      run_q   <= 1'b0;
      wd_q    <= '0;
      two_q   <= 1'b0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      din_q   <= din_d;
      run_q   <= run_d;
      wd_q    <= wd_d;
      two_q   <= two_d;
      br_q    <= br_d;
    end

  assign cpu.DIN     = din_q;
  assign cpu.Run     = run_q;
  assign pc          = pc_q;
  assign busy        = (state_q == S_ISSUE) || (state_q == S_OPERAND) || (state_q == S_WAIT);
  assign halted      = (state_q == S_HALT);
  assign timeout_err = (state_q == S_ERR);
endmodule

// File: tb/tb_cute_program_feeder.sv
// Scoreboard bench: a reference walk of the loaded program queues the expected
// issue trace, which is popped as the feeder raises Run.
module tb_cute_program_feeder;
  localparam int DW = 9;
  localparam int AW = 5;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] din;
    logic [DW-1:0] opnd;
    bit            two;
  } exp_t;

  logic          clk = 1'b0;
  logic          Reset = 1'b0;
  logic          start = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic [AW-1:0] pc;
  logic          busy, halted, timeout_err;
  logic [AW+DW+3:0] outs;

  exp_t          exp_q[$];
  logic [DW-1:0] tb_mem [32];
  logic [AW-1:0] exp_pc_final;
  int            tests = 0;
  int            fails = 0;

  cute_program_feeder_if #(.DW(DW)) cif ();

  cute_program_feeder #(.DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .start       (start),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .cpu         (cif),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  assign outs = {pc, cif.DIN, cif.Run, busy, halted, timeout_err};

  task automatic do_reset();
    @(negedge clk);
    Reset = 1'b1; start = 1'b0; load_en = 1'b0; cif.done = 1'b0; cif.jmp = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_addr = a; load_data = d; load_en = 1'b1;
    @(posedge clk); #1 load_en = 1'b0;
    tb_mem[a] = d;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 32; a++) load_word(AW'(a), '0);
  endtask

  // Reference walk of tb_mem from address 0; jv is the jmp answer for every branch.
  task automatic build_expect(input bit jv);
    logic [AW-1:0] p;
    logic [DW-1:0] w;
    exp_t e;
    p = '0;
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      w = tb_mem[p];
      if (w == 9'h000) break;
      e.pc = p; e.din = w; e.opnd = tb_mem[p + 5'd1];
      e.two = (w[8:6] == 3'b001) || (w[8:6] == 3'b111);
      exp_q.push_back(e);
      if (w[8:6] == 3'b111 && jv) p = tb_mem[p + 5'd1][4:0];
      else if (e.two)             p = p + 5'd2;
      else                        p = p + 5'd1;
    end
    exp_pc_final = p;
  endtask

  // Pulse start, answer done dly cycles after each Run (or operand), compare the trace.
  task automatic run_prog(input int dly, input bit jv);
    exp_t e;
    int cyc;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (halted !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cif.Run === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL issue_extra: got DIN=%h pc=%0d, required no further Run", cif.DIN, pc);
        end else begin
          e = exp_q.pop_front();
          if (cif.DIN !== e.din || pc !== e.pc) begin
            fails++;
            $display("FAIL issue: got DIN=%h pc=%0d, required DIN=%h pc=%0d", cif.DIN, pc, e.din, e.pc);
          end
          if (e.two) begin
            @(negedge clk);
            tests++;
            if (cif.DIN !== e.opnd || cif.Run !== 1'b0) begin
              fails++;
              $display("FAIL operand: got DIN=%h Run=%b, required DIN=%h Run=0", cif.DIN, cif.Run, e.opnd);
            end
          end
        end
        repeat (dly) @(posedge clk);
        #1 cif.done = 1'b1; cif.jmp = jv;
        @(posedge clk); #1 cif.done = 1'b0; cif.jmp = 1'b0;
      end
    end
    tests++;
    if (halted !== 1'b1 || timeout_err !== 1'b0 || pc !== exp_pc_final) begin
      fails++;
      $display("FAIL halt_state: got halted=%b err=%b pc=%0d, required halted=1 err=0 pc=%0d",
               halted, timeout_err, pc, exp_pc_final);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL issue_missing: %0d expected issues never seen, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    #1 Reset = 1'b1;
    #1;
    tests++;
    if (outs !== '0) begin
      fails++; $display("FAIL reset_async: got outputs=%h, required 0", outs);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (outs !== '0) begin
      fails++; $display("FAIL reset_held: got outputs=%h, required 0", outs);
    end
    @(negedge clk) Reset = 1'b0;
    @(negedge clk);
    tests++;
    if (outs !== '0) begin
      fails++; $display("FAIL reset_idle: got outputs=%h, required 0", outs);
    end
  endtask

  task automatic test_linear();
    do_reset(); clear_mem();
    load_word(0, 9'h081); load_word(1, 9'h092); load_word(2, 9'h000);
    build_expect(0); run_prog(2, 0);
    // a write strobe while halted must not touch the program
    load_addr = 0; load_data = 9'h0C5; load_en = 1'b1;
    @(posedge clk); #1 load_en = 1'b0;
    @(negedge clk);
    tests++;
    if (halted !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL halt_load: got halted=%b busy=%b, required halted=1 busy=0", halted, busy);
    end
    build_expect(0); run_prog(2, 0);
  endtask

  task automatic test_imm();
    do_reset(); clear_mem();
    load_word(0, 9'h040); load_word(1, 9'd77); load_word(2, 9'h000);
    build_expect(0); run_prog(2, 0);
  endtask

  task automatic test_branch();
    do_reset(); clear_mem();
    load_word(0, 9'h1C0); load_word(1, 9'd5); load_word(2, 9'h092);
    load_word(5, 9'h081);
    build_expect(1); run_prog(1, 1);
    build_expect(0); run_prog(1, 0);
  endtask

  task automatic test_timeout();
    int n;
    do_reset(); clear_mem();
    load_word(0, 9'h081);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) break;
      if (busy === 1'b1) n++;
    end
    tests++;
    if (timeout_err !== 1'b1 || n !== 15) begin
      fails++; $display("FAIL timeout_cycles: got err=%b after %0d WAIT cycles, required err=1 after 15", timeout_err, n);
    end
    @(posedge clk); #1 cif.done = 1'b1;
    @(posedge clk); #1 cif.done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || cif.Run !== 1'b0 || cif.DIN !== '0) begin
      fails++;
      $display("FAIL timeout_sticky: got err=%b busy=%b Run=%b DIN=%h, required err=1 busy=0 Run=0 DIN=0",
               timeout_err, busy, cif.Run, cif.DIN);
    end
    build_expect(0); run_prog(1, 0);
  endtask

  task automatic test_reset_mid();
    do_reset(); clear_mem();
    load_word(0, 9'h081); load_word(1, 9'h092); load_word(2, 9'h000);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 cif.done = 1'b1;
    @(posedge clk); #1 cif.done = 1'b0;
    @(negedge clk);
    tests++;
    if (cif.Run !== 1'b1 || pc !== 5'd1 || cif.DIN !== 9'h092) begin
      fails++; $display("FAIL pre_reset: got Run=%b pc=%0d DIN=%h, required Run=1 pc=1 DIN=092", cif.Run, pc, cif.DIN);
    end
    #2 Reset = 1'b1;
    #1;
    tests++;
    if (outs !== '0) begin
      fails++; $display("FAIL reset_mid: got outputs=%h, required 0", outs);
    end
    @(negedge clk) Reset = 1'b0;
    build_expect(0); run_prog(1, 0);
  endtask

  task automatic test_boundary();
    do_reset(); clear_mem();
    load_word(0, 9'h1C0); load_word(1, 9'd31); load_word(31, 9'h040);
    load_addr = 2; load_data = 9'h092; load_en = 1'b1; start = 1'b1;
    @(posedge clk); #1 load_en = 1'b0; start = 1'b0;
    tb_mem[2] = 9'h092;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || cif.Run !== 1'b0) begin
      fails++; $display("FAIL start_with_load: got busy=%b Run=%b, required busy=0 Run=0", busy, cif.Run);
    end
    build_expect(1); run_prog(1, 1);
  endtask

  initial begin
    cif.done = 1'b0;
    cif.jmp  = 1'b0;
    test_reset();
    test_linear();
    test_imm();
    test_branch();
    test_timeout();
    test_reset_mid();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end
endmodule
